// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Program counter owner and instruction-fetch sequencer for the
//             32-bit MIPS core. Picks the next PC from sequential, branch,
//             jump or jump-register sources. Fetches go over a req/ack
//             handshake, and a fetch that waits too long raises a sticky
//             timeout.
//  Options  : PC_ALIGN_CHECK_EN - adds the sticky jr_misalign flag for jr
//             targets that are not word aligned.
//  Revision : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic        stall,
  input  logic        br_take,
  input  logic [15:0] br_imm,
  input  logic        jmp,
  input  logic [25:0] jmp_target,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic        timeout
`ifdef PC_ALIGN_CHECK_EN
  ,output logic       jr_misalign
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    ERROR = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(IMEM_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;
  logic [31:0] next_addr;
  logic [31:0] jr_target;
  logic [31:0] br_offset;
  logic        advance;

  assign pc_plus4 = pc + 32'd4;
  // A new address is taken only when an issued instruction is released.
  assign advance  = (state == ISSUE) && !stall;

  // Next-address select, priority jr > jmp > branch > sequential.
  always_comb begin
    jr_target = jr_addr & 32'hFFFF_FFFC;
    br_offset = {{14{br_imm[15]}}, br_imm, 2'b00};
    next_addr = pc_plus4;
    if (jr)
      next_addr = jr_target;
    else if (jmp)
      next_addr = {pc_plus4[31:28], jmp_target, 2'b00};
    else if (br_take)
      next_addr = pc_plus4 + br_offset;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Next-state and output decode.
  always_comb begin
    state_nxt   = state;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    timeout     = 1'b0;
    case (state)
      IDLE: begin
        if (run)
          state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack)
          state_nxt = ISSUE;
        else if (wait_cnt == TIMEOUT_LAST)
          state_nxt = ERROR;
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (!stall)
          state_nxt = run ? FETCH : IDLE;
      end
      default: begin
        timeout = 1'b1;
      end
    endcase
  end

  // PC, fetch address and fetch-wait counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      imem_addr <= RESET_PC;
      wait_cnt  <= 8'd0;
    end else begin
      if (state == FETCH && imem_ack)
        pc <= imem_addr;
      if (advance)
        imem_addr <= next_addr;
      if (state == FETCH && !imem_ack)
        wait_cnt <= wait_cnt + 8'd1;
      else
        wait_cnt <= 8'd0;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  // Sticky flag for a selected jr whose target is not word aligned.
  always_ff @(posedge clk) begin
    if (!rst_n)
      jr_misalign <= 1'b0;
    else if (advance && jr && (jr_addr[1:0] != 2'b00))
      jr_misalign <= 1'b1;
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Directed self-checking bench for pc_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        stall = 1'b0;
  logic        br_take = 1'b0;
  logic [15:0] br_imm = 16'h0;
  logic        jmp = 1'b0;
  logic [25:0] jmp_target = 26'h0;
  logic        jr = 1'b0;
  logic [31:0] jr_addr = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic        timeout;
`ifdef PC_ALIGN_CHECK_EN
  logic        jr_misalign;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  pc_sequencer #(
    .RESET_PC    (32'h0000_0000),
    .IMEM_TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .run        (run),
    .stall      (stall),
    .br_take    (br_take),
    .br_imm     (br_imm),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .jr         (jr),
    .jr_addr    (jr_addr),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .pc         (pc),
    .pc_plus4   (pc_plus4),
    .instr_valid(instr_valid),
    .timeout    (timeout)
`ifdef PC_ALIGN_CHECK_EN
    ,.jr_misalign(jr_misalign)
`endif
  );

  always #5 clk = ~clk;

  // Advance one clock and settle 1 ns past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // In FETCH: check the request, ack it, then check the issued instruction.
  task automatic issue_at(input logic [31:0] a);
    check("fetch_req", {31'b0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, a);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("issue_valid", {31'b0, instr_valid}, 32'd1);
    check("issue_req", {31'b0, imem_req}, 32'd0);
    check("issue_pc", pc, a);
    check("issue_pc4", pc_plus4, a + 32'd4);
  endtask

  // In ISSUE: present redirect inputs for one edge, then clear them.
  task automatic redirect(input logic bt, input logic [15:0] bi, input logic j,
                          input logic [25:0] jt, input logic r, input logic [31:0] ra);
    br_take = bt; br_imm = bi; jmp = j; jmp_target = jt; jr = r; jr_addr = ra;
    tick();
    br_take = 1'b0; br_imm = 16'h0; jmp = 1'b0; jmp_target = 26'h0; jr = 1'b0; jr_addr = 32'h0;
  endtask

  task automatic check_reset_state();
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_timeout", {31'b0, timeout}, 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_addr", imem_addr, 32'h0);
`ifdef PC_ALIGN_CHECK_EN
    check("rst_misalign", {31'b0, jr_misalign}, 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset
    tick(); tick();
    check_reset_state();
    rst_n = 1'b1;
    run   = 1'b1;
    tick();

    // Sequential fetch 0, 4, 8 at one instruction per two cycles
    issue_at(32'h0);
    redirect(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    issue_at(32'h4);
    redirect(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    issue_at(32'h8);

    // Branches from 0x100: backward by 2 words, forward by 3 words
    redirect(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h100);
    issue_at(32'h100);
    redirect(1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0);
    issue_at(32'h0FC);
    redirect(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h100);
    issue_at(32'h100);
    redirect(1'b1, 16'h0003, 1'b0, 26'h0, 1'b0, 32'h0);
    issue_at(32'h110);

    // Jump beats a simultaneous taken branch
    redirect(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h3000_0010);
    issue_at(32'h3000_0010);
    redirect(1'b1, 16'h0005, 1'b1, 26'h0000040, 1'b0, 32'h0);
    issue_at(32'h3000_0100);

    // Stall for 3 cycles with jr requested; jr dropped before release
    stall = 1'b1; jr = 1'b1; jr_addr = 32'h500;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin jr = 1'b0; jr_addr = 32'h0; end
      tick();
      check("stall_valid", {31'b0, instr_valid}, 32'd1);
      check("stall_pc", pc, 32'h3000_0100);
      check("stall_req", {31'b0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    tick();
    issue_at(32'h3000_0104);

    // Wrap-around from the top of the address space
    redirect(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'hFFFF_FFFC);
    issue_at(32'hFFFF_FFFC);
    redirect(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    issue_at(32'h0);

    // Halt, stray ack in IDLE, resume at the retained address
    run = 1'b0;
    redirect(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    check("idle_req", {31'b0, imem_req}, 32'd0);
    check("idle_valid", {31'b0, instr_valid}, 32'd0);
    check("idle_addr", imem_addr, 32'h4);
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    check("idle_ack_pc", pc, 32'h0);
    check("idle_ack_valid", {31'b0, instr_valid}, 32'd0);
    run = 1'b1;
    tick();
    // Redirect during FETCH has no effect on the pending address
    jr = 1'b1; jr_addr = 32'h700;
    tick();
    jr = 1'b0; jr_addr = 32'h0;
    check("fetch_hold_addr", imem_addr, 32'h4);
    issue_at(32'h4);

    // Misaligned jr target is word-aligned for the fetch
`ifdef PC_ALIGN_CHECK_EN
    check("misalign_before", {31'b0, jr_misalign}, 32'd0);
`endif
    redirect(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, 32'h0000_0206);
`ifdef PC_ALIGN_CHECK_EN
    check("misalign_set", {31'b0, jr_misalign}, 32'd1);
`endif
    issue_at(32'h204);

    // Fetch timeout: no ack for IMEM_TIMEOUT cycles
    redirect(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    for (int i = 0; i < 15; i++) tick();
    check("to_still_fetch", {31'b0, imem_req}, 32'd1);
    check("to_not_yet", {31'b0, timeout}, 32'd0);
    tick();
    check("to_flag", {31'b0, timeout}, 32'd1);
    check("to_req", {31'b0, imem_req}, 32'd0);
    imem_ack = 1'b1;
    tick(); tick();
    check("to_sticky", {31'b0, timeout}, 32'd1);
    check("to_req_off", {31'b0, imem_req}, 32'd0);
    check("to_valid_off", {31'b0, instr_valid}, 32'd0);

    // One-cycle reset, with a coincident ack, clears everything
    rst_n = 1'b0;
    tick();
    imem_ack = 1'b0;
    check_reset_state();
    rst_n = 1'b1;
    tick();
    issue_at(32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
